// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_pkg : state codes and default timing parameters for the sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seq_pkg;

   localparam logic [3:0] Q0 = 4'd0;
   localparam logic [3:0] Q1 = 4'd1;
   localparam logic [3:0] Q2 = 4'd2;
   localparam logic [3:0] Q3 = 4'd3;
   localparam logic [3:0] Q4 = 4'd4;
   localparam logic [3:0] Q5 = 4'd5;
   localparam logic [3:0] Q6 = 4'd6;
   localparam logic [3:0] Q7 = 4'd7;
   localparam logic [3:0] Q8 = 4'd8;
   localparam logic [3:0] Q9 = 4'd9;

   localparam int NSTATES = 10;
   localparam int ANN_W   = 10;

   localparam int DEFAULT_NBITS       = 27;
   localparam int DEFAULT_NCLKS_TOTAL = 96830000;

endpackage
`default_nettype wire

// File: rtl/cycle_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cycle_counter : modulo-NCLKS_TOTAL cycle counter with sync clear      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cycle_counter
   import seq_pkg::*;
#(
   parameter int NBITS       = DEFAULT_NBITS,
   parameter int NCLKS_TOTAL = DEFAULT_NCLKS_TOTAL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   output logic [NBITS-1:0] count
);

   localparam logic [NBITS-1:0] LAST = NBITS'(NCLKS_TOTAL - 1);
   localparam logic [NBITS-1:0] ONE  = NBITS'(1);

   // clr has priority over the wrap so a coincident clear is a single zeroing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/out_definer_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | out_definer_counter : sequencer cycle counter + one-hot state decoder |
// | Optional macro WRAP_PULSE_EN adds the wrap_pulse output. Rev 1.0      |
// +----------------------------------------------------------------------+
module out_definer_counter
   import seq_pkg::*;
#(
   parameter int NBITS       = DEFAULT_NBITS,
   parameter int NCLKS_TOTAL = DEFAULT_NCLKS_TOTAL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic [3:0]       state,
   output logic [NBITS-1:0] counter_out,
   output logic [ANN_W-1:0] state_announcement
`ifdef WRAP_PULSE_EN
   ,
   output logic             wrap_pulse
`endif
);

   cycle_counter #(
      .NBITS       (NBITS),
      .NCLKS_TOTAL (NCLKS_TOTAL)
   ) u_cycle_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .count (counter_out)
   );

   // Out-of-range codes decode to all zeros rather than aliasing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_announcement <= '0;
      end else if (int'(state) < NSTATES) begin
         state_announcement <= ANN_W'(1) << state;
      end else begin
         state_announcement <= '0;
      end
   end

`ifdef WRAP_PULSE_EN
   localparam logic [NBITS-1:0] LAST = NBITS'(NCLKS_TOTAL - 1);

   // Only a natural rollover pulses; a clear landing on LAST does not
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrap_pulse <= 1'b0;
      end else begin
         wrap_pulse <= !clr && (counter_out == LAST);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_out_definer_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_out_definer_counter : scoreboard bench for out_definer_counter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_out_definer_counter;

   localparam int FSM_N = 20000;

   logic        clk;
   logic        reset;
   logic        clr;
   logic        clr_s;
   logic [3:0]  state;
   logic [26:0] counter_out;
   logic [9:0]  state_announcement;
   logic [3:0]  counter_out_s;
   logic [9:0]  state_announcement_s;
`ifdef WRAP_PULSE_EN
   logic        wrap_pulse;
   logic        wrap_pulse_s;
`endif

   out_definer_counter dut (
      .clk                (clk),
      .reset              (reset),
      .clr                (clr),
      .state              (state),
      .counter_out        (counter_out),
      .state_announcement (state_announcement)
`ifdef WRAP_PULSE_EN
      ,
      .wrap_pulse         (wrap_pulse)
`endif
   );

   // Short-modulus copy so wrap behaviour is reachable in a few cycles
   out_definer_counter #(
      .NBITS       (4),
      .NCLKS_TOTAL (8)
   ) dut_s (
      .clk                (clk),
      .reset              (reset),
      .clr                (clr_s),
      .state              (state),
      .counter_out        (counter_out_s),
      .state_announcement (state_announcement_s)
`ifdef WRAP_PULSE_EN
      ,
      .wrap_pulse         (wrap_pulse_s)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int    which;
      string tag;
      int    exp;
   } sb_item_t;

   sb_item_t sb[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic push(input int which, input string tag, input int exp);
      sb_item_t it;
      it.which = which;
      it.tag   = tag;
      it.exp   = exp;
      sb.push_back(it);
   endtask

   task automatic drain();
      sb_item_t it;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         case (it.which)
            0: check(it.tag, 32'(counter_out), it.exp);
            1: check(it.tag, 32'(counter_out_s), it.exp);
            2: check(it.tag, 32'(state_announcement), it.exp);
`ifdef WRAP_PULSE_EN
            3: check(it.tag, 32'(wrap_pulse_s), it.exp);
`endif
            default: check(it.tag, 32'(state_announcement_s), it.exp);
         endcase
      end
   endtask

   task automatic edge_chk();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ev_cyc[3];
      int events;
      int unsigned prev;
      logic nclr;

      reset = 1'b0;
      clr   = 1'b0;
      clr_s = 1'b0;
      state = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      push(0, "rst_cnt", 0);
      push(1, "rst_cnt_s", 0);
      push(2, "rst_ann", 0);
`ifdef WRAP_PULSE_EN
      push(3, "rst_wrap", 0);
`endif
      drain();

      // Release, then count up to ~300 with a valid state loaded
      reset = 1'b1;
      state = 4'd5;
      push(0, "cnt_first", 1);
      push(2, "ann_q5", 32'h020);
      edge_chk();
      repeat (299) edge_chk();
      push(0, "cnt_300", 300);
      push(4, "ann_s_q5", 32'h020);
      drain();

      // Asynchronous reset mid-cycle, held for 5 edges
      #2;
      reset = 1'b0;
      #1;
      push(0, "rst_async_cnt", 0);
      push(2, "rst_async_ann", 0);
      drain();
      for (int i = 0; i < 5; i++) begin
         push(0, "rst_hold_cnt", 0);
         push(2, "rst_hold_ann", 0);
         edge_chk();
      end
      reset = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         push(0, "cnt_after_rel", i);
         push(1, "cnt_s_after_rel", i);
         edge_chk();
      end

      // Free run through a wrap on the short counter
      do_reset();
      push(1, "free_0", 0);
`ifdef WRAP_PULSE_EN
      push(3, "wrap_free_0", 0);
`endif
      drain();
      for (int i = 1; i <= 9; i++) begin
         push(1, "free_seq", i % 8);
`ifdef WRAP_PULSE_EN
         push(3, "wrap_seq", (i == 8) ? 1 : 0);
`endif
         edge_chk();
      end

      // Single-cycle clear at 17, then a 3-cycle held clear
      do_reset();
      repeat (17) edge_chk();
      push(0, "cnt_17", 17);
      drain();
      clr = 1'b1;
      push(0, "clr_pulse", 0);
      edge_chk();
      clr = 1'b0;
      push(0, "clr_pulse_next", 1);
      edge_chk();
      clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(0, "clr_held", 0);
         edge_chk();
      end
      clr = 1'b0;
      push(0, "clr_held_rel", 1);
      edge_chk();

      // Clear coinciding with the wrap condition
      do_reset();
      repeat (7) edge_chk();
      push(1, "cnt_s_7", 7);
      drain();
      clr_s = 1'b1;
      push(1, "clr_at_last", 0);
`ifdef WRAP_PULSE_EN
      push(3, "wrap_on_clr", 0);
`endif
      edge_chk();
      clr_s = 1'b0;
      push(1, "clr_at_last_next", 1);
`ifdef WRAP_PULSE_EN
      push(3, "wrap_after_clr", 0);
`endif
      edge_chk();

      // Decoder sweep across every 4-bit code
      for (int s = 0; s < 16; s++) begin
         state = 4'(s);
         push(2, "ann_sweep", (s < 10) ? (1 << s) : 0);
         push(4, "ann_s_sweep", (s < 10) ? (1 << s) : 0);
         edge_chk();
      end

      // FSM-style loop with a registered, non-repeating done pulse
      do_reset();
      events = 0;
      prev   = 0;
      for (int cyc = 0; cyc < 65000 && events < 3; cyc++) begin
         edge_chk();
         nclr = (prev >= FSM_N - 2) && !clr;
         prev = 32'(counter_out);
         clr  = nclr;
         if (nclr) begin
            push(0, "fsm_zero", 0);
            ev_cyc[events] = cyc;
            events++;
         end
      end
      edge_chk();
      clr = 1'b0;
      check("fsm_events", events, 3);
      if (events == 3) begin
         check("fsm_period_1", ev_cyc[1] - ev_cyc[0], FSM_N);
         check("fsm_period_2", ev_cyc[2] - ev_cyc[1], FSM_N);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
